// File: rtl/tl_buffer_param_if.sv
// TileLink-UH A/D channel bundle shared by the client-facing and manager-facing sides of tl_buffer_param.
// The master modport is the client end: it drives A and accepts D.
interface tl_buffer_param_if #(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 7,
    parameter int SIZE_W = 4,
    parameter int SINK_W = 1
);
    localparam int MASK_W = DATA_W / 8;

    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [SIZE_W-1:0] a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic [MASK_W-1:0] a_mask;
    logic [DATA_W-1:0] a_data;
    logic              a_corrupt;

    logic              d_valid;
    logic              d_ready;
    logic [2:0]        d_opcode;
    logic [1:0]        d_param;
    logic [SIZE_W-1:0] d_size;
    logic [SRC_W-1:0]  d_source;
    logic [SINK_W-1:0] d_sink;
    logic              d_denied;
    logic [DATA_W-1:0] d_data;
    logic              d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_buffer_param.sv
// TileLink-UH A/D buffer: one independent FIFO per channel with per-channel depth, pipe and flow modes.
// A zero-depth channel degenerates to plain wires.
module tl_buffer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter bit PIPE  = 1'b0,
    parameter bit FLOW  = 1'b0,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enq_valid,
    output logic          enq_ready,
    input  logic [W-1:0]  enq_bits,
    output logic          deq_valid,
    input  logic          deq_ready,
    output logic [W-1:0]  deq_bits,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_s, full_s, bypass_s, do_enq_s, do_deq_s;

    // Handshake, bypass decision and next-state pointers/count.
    always_comb begin
        empty_s   = (count_q == {CW{1'b0}});
        full_s    = (count_q == CW'(DEPTH));
        enq_ready = !full_s || (PIPE && deq_ready);
        deq_valid = !empty_s || (FLOW && enq_valid);
        if (FLOW && empty_s) begin
            deq_bits = enq_bits;
        end else begin
            deq_bits = mem_q[rp_q];
        end
        // A flow-through beat taken by the consumer never touches storage.
        bypass_s = FLOW && empty_s && deq_ready;
        do_enq_s = enq_valid && enq_ready && !bypass_s;
        do_deq_s = deq_valid && deq_ready && !bypass_s;

        wp_d = wp_q;
        if (do_enq_s) begin
            wp_d = (wp_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wp_q + PW'(1);
        end else begin
            wp_d = wp_q;
        end
        rp_d = rp_q;
        if (do_deq_s) begin
            rp_d = (rp_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rp_q + PW'(1);
        end else begin
            rp_d = rp_q;
        end
        case ({do_enq_s, do_deq_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q    <= {PW{1'b0}};
            rp_q    <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entry storage; left uninitialised on reset since count gates every read.
    always_ff @(posedge clock) begin
        if (do_enq_s) begin
            mem_q[wp_q] <= enq_bits;
        end
    end

    assign count = count_q;
endmodule

module tl_buffer_param #(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int A_PIPE  = 0,
    parameter int A_FLOW  = 0,
    parameter int D_PIPE  = 0,
    parameter int D_FLOW  = 0,
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 7,
    parameter int SIZE_W  = 4,
    parameter int SINK_W  = 1,
    localparam int MASK_W = DATA_W / 8,
    localparam int A_CW   = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
    localparam int D_CW   = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    tl_buffer_param_if.slave       auto_in,
    tl_buffer_param_if.master      auto_out,
    output logic [A_CW-1:0]        a_count,
    output logic [D_CW-1:0]        d_count,
    output logic                   idle
);
    localparam int A_W = 3 + 3 + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W + 1;
    localparam int D_W = 3 + 2 + SIZE_W + SRC_W + SINK_W + 1 + DATA_W + 1;

    logic [A_W-1:0] a_in_s, a_out_s;
    logic [D_W-1:0] d_in_s, d_out_s;

    assign a_in_s = {auto_in.a_opcode, auto_in.a_param, auto_in.a_size, auto_in.a_source,
                     auto_in.a_address, auto_in.a_mask, auto_in.a_data, auto_in.a_corrupt};
    assign {auto_out.a_opcode, auto_out.a_param, auto_out.a_size, auto_out.a_source,
            auto_out.a_address, auto_out.a_mask, auto_out.a_data, auto_out.a_corrupt} = a_out_s;

    assign d_in_s = {auto_out.d_opcode, auto_out.d_param, auto_out.d_size, auto_out.d_source,
                     auto_out.d_sink, auto_out.d_denied, auto_out.d_data, auto_out.d_corrupt};
    assign {auto_in.d_opcode, auto_in.d_param, auto_in.d_size, auto_in.d_source,
            auto_in.d_sink, auto_in.d_denied, auto_in.d_data, auto_in.d_corrupt} = d_out_s;

    if (A_DEPTH == 0) begin : g_a_wire
        assign auto_out.a_valid = auto_in.a_valid;
        assign auto_in.a_ready  = auto_out.a_ready;
        assign a_out_s          = a_in_s;
        assign a_count          = {A_CW{1'b0}};
    end else begin : g_a_fifo
        tl_buffer_fifo #(
            .W(A_W), .DEPTH(A_DEPTH), .PIPE(A_PIPE != 0), .FLOW(A_FLOW != 0)
        ) u_fifo (
            .clock(clock), .reset(reset),
            .enq_valid(auto_in.a_valid), .enq_ready(auto_in.a_ready), .enq_bits(a_in_s),
            .deq_valid(auto_out.a_valid), .deq_ready(auto_out.a_ready), .deq_bits(a_out_s),
            .count(a_count)
        );
    end

    if (D_DEPTH == 0) begin : g_d_wire
        assign auto_in.d_valid  = auto_out.d_valid;
        assign auto_out.d_ready = auto_in.d_ready;
        assign d_out_s          = d_in_s;
        assign d_count          = {D_CW{1'b0}};
    end else begin : g_d_fifo
        tl_buffer_fifo #(
            .W(D_W), .DEPTH(D_DEPTH), .PIPE(D_PIPE != 0), .FLOW(D_FLOW != 0)
        ) u_fifo (
            .clock(clock), .reset(reset),
            .enq_valid(auto_out.d_valid), .enq_ready(auto_out.d_ready), .enq_bits(d_in_s),
            .deq_valid(auto_in.d_valid), .deq_ready(auto_in.d_ready), .deq_bits(d_out_s),
            .count(d_count)
        );
    end

    // Derived only from the registered counts, so no input reaches it combinationally.
    assign idle = (a_count == {A_CW{1'b0}}) && (d_count == {D_CW{1'b0}});
endmodule

// File: tb/tb_tl_buffer_param.sv
// Directed bench for tl_buffer_param: four configurations (2/2 with D flow, A depth 3, A depth 1 pipe,
// all-wire) driven from one clock, each result compared against a hand-computed constant.
module tb_tl_buffer_param;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    tl_buffer_param_if i0 (); tl_buffer_param_if o0 ();
    tl_buffer_param_if i1 (); tl_buffer_param_if o1 ();
    tl_buffer_param_if i2 (); tl_buffer_param_if o2 ();
    tl_buffer_param_if i3 (); tl_buffer_param_if o3 ();

    logic [1:0] a_cnt0, d_cnt0, a_cnt1, d_cnt1, d_cnt2;
    logic [0:0] a_cnt2, a_cnt3, d_cnt3;
    logic       idle0, idle1, idle2, idle3;

    tl_buffer_param #(.A_DEPTH(2), .D_DEPTH(2), .D_FLOW(1)) dut0 (
        .clock(clock), .reset(reset), .auto_in(i0), .auto_out(o0),
        .a_count(a_cnt0), .d_count(d_cnt0), .idle(idle0));
    tl_buffer_param #(.A_DEPTH(3), .D_DEPTH(2)) dut1 (
        .clock(clock), .reset(reset), .auto_in(i1), .auto_out(o1),
        .a_count(a_cnt1), .d_count(d_cnt1), .idle(idle1));
    tl_buffer_param #(.A_DEPTH(1), .A_PIPE(1), .D_DEPTH(2)) dut2 (
        .clock(clock), .reset(reset), .auto_in(i2), .auto_out(o2),
        .a_count(a_cnt2), .d_count(d_cnt2), .idle(idle2));
    tl_buffer_param #(.A_DEPTH(0), .D_DEPTH(0)) dut3 (
        .clock(clock), .reset(reset), .auto_in(i3), .auto_out(o3),
        .a_count(a_cnt3), .d_count(d_cnt3), .idle(idle3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic zero_inputs();
        {i0.a_valid, i0.a_opcode, i0.a_param, i0.a_size, i0.a_source, i0.a_address, i0.a_mask, i0.a_data, i0.a_corrupt, i0.d_ready} = '0;
        {i1.a_valid, i1.a_opcode, i1.a_param, i1.a_size, i1.a_source, i1.a_address, i1.a_mask, i1.a_data, i1.a_corrupt, i1.d_ready} = '0;
        {i2.a_valid, i2.a_opcode, i2.a_param, i2.a_size, i2.a_source, i2.a_address, i2.a_mask, i2.a_data, i2.a_corrupt, i2.d_ready} = '0;
        {i3.a_valid, i3.a_opcode, i3.a_param, i3.a_size, i3.a_source, i3.a_address, i3.a_mask, i3.a_data, i3.a_corrupt, i3.d_ready} = '0;
        {o0.a_ready, o0.d_valid, o0.d_opcode, o0.d_param, o0.d_size, o0.d_source, o0.d_sink, o0.d_denied, o0.d_data, o0.d_corrupt} = '0;
        {o1.a_ready, o1.d_valid, o1.d_opcode, o1.d_param, o1.d_size, o1.d_source, o1.d_sink, o1.d_denied, o1.d_data, o1.d_corrupt} = '0;
        {o2.a_ready, o2.d_valid, o2.d_opcode, o2.d_param, o2.d_size, o2.d_source, o2.d_sink, o2.d_denied, o2.d_data, o2.d_corrupt} = '0;
        {o3.a_ready, o3.d_valid, o3.d_opcode, o3.d_param, o3.d_size, o3.d_source, o3.d_sink, o3.d_denied, o3.d_data, o3.d_corrupt} = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        zero_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        settle();

        // Post-reset state.
        chk("rst_a_count", 64'(a_cnt0), 64'd0);
        chk("rst_idle", 64'(idle0), 64'd1);
        chk("rst_in_a_ready", 64'(i0.a_ready), 64'd1);
        chk("rst_out_a_valid", 64'(o0.a_valid), 64'd0);
        chk("rst_in_d_valid", 64'(i0.d_valid), 64'd0);
        chk("rst_out_d_ready", 64'(o0.d_ready), 64'd1);

        // Depth-2 fill with the manager stalled, then drain in order.
        o0.a_ready = 1'b0;
        i0.a_valid = 1'b1; i0.a_opcode = 3'd4; i0.a_source = 7'd5;
        i0.a_address = 29'h1000; i0.a_data = 64'hDEAD; i0.a_mask = 8'hFF;
        settle();
        chk("t1_no_comb_path", 64'(o0.a_valid), 64'd0);
        step();
        i0.a_source = 7'd6; i0.a_address = 29'h1008; i0.a_data = 64'hBEEF;
        settle();
        chk("t1_out_valid", 64'(o0.a_valid), 64'd1);
        chk("t1_out_opcode", 64'(o0.a_opcode), 64'd4);
        chk("t1_out_source", 64'(o0.a_source), 64'd5);
        chk("t1_out_address", 64'(o0.a_address), 64'h1000);
        chk("t1_out_data", 64'(o0.a_data), 64'hDEAD);
        chk("t1_count1", 64'(a_cnt0), 64'd1);
        chk("t1_idle0", 64'(idle0), 64'd0);
        step();
        i0.a_source = 7'd7; i0.a_data = 64'h7777;
        settle();
        chk("t1_count2", 64'(a_cnt0), 64'd2);
        chk("t1_full_ready", 64'(i0.a_ready), 64'd0);
        step();
        i0.a_valid = 1'b0;
        settle();
        chk("t1_refused_count", 64'(a_cnt0), 64'd2);
        chk("t1_stall_stable", 64'(o0.a_data), 64'hDEAD);
        o0.a_ready = 1'b1;
        settle();
        chk("t1_drain0_src", 64'(o0.a_source), 64'd5);
        step();
        chk("t1_drain1_src", 64'(o0.a_source), 64'd6);
        chk("t1_drain1_data", 64'(o0.a_data), 64'hBEEF);
        chk("t1_drain1_count", 64'(a_cnt0), 64'd1);
        step();
        chk("t1_empty_valid", 64'(o0.a_valid), 64'd0);
        chk("t1_empty_count", 64'(a_cnt0), 64'd0);
        chk("t1_empty_idle", 64'(idle0), 64'd1);

        // Depth-3 streaming across pointer wrap.
        o1.a_ready = 1'b1;
        i1.a_valid = 1'b1; i1.a_source = 7'd0;
        settle();
        chk("t2_first_valid", 64'(o1.a_valid), 64'd0);
        step();
        for (int k = 1; k <= 10; k++) begin
            if (k < 10) i1.a_source = 7'(k);
            else        i1.a_valid  = 1'b0;
            settle();
            chk("t2_order", 64'(o1.a_source), 64'(k - 1));
            chk("t2_count", 64'(a_cnt1), 64'd1);
            step();
        end
        chk("t2_end_count", 64'(a_cnt1), 64'd0);
        chk("t2_end_valid", 64'(o1.a_valid), 64'd0);

        // D flow-through into an empty FIFO.
        o0.d_valid = 1'b1; o0.d_data = 64'h1234; o0.d_source = 7'd3;
        i0.d_ready = 1'b1;
        settle();
        chk("t3_flow_valid", 64'(i0.d_valid), 64'd1);
        chk("t3_flow_data", 64'(i0.d_data), 64'h1234);
        chk("t3_flow_source", 64'(i0.d_source), 64'd3);
        chk("t3_flow_ready", 64'(o0.d_ready), 64'd1);
        step();
        chk("t3_flow_count", 64'(d_cnt0), 64'd0);
        o0.d_valid = 1'b0;

        // Depth-1 pipe: full FIFO replaces its entry every cycle.
        o2.a_ready = 1'b0;
        i2.a_valid = 1'b1; i2.a_source = 7'd1;
        step();
        chk("t4_full_count", 64'(a_cnt2), 64'd1);
        chk("t4_full_ready", 64'(i2.a_ready), 64'd0);
        chk("t4_full_src", 64'(o2.a_source), 64'd1);
        o2.a_ready = 1'b1; i2.a_source = 7'd2;
        settle();
        chk("t4_pipe_ready", 64'(i2.a_ready), 64'd1);
        step();
        chk("t4_pipe_src2", 64'(o2.a_source), 64'd2);
        chk("t4_pipe_count2", 64'(a_cnt2), 64'd1);
        i2.a_source = 7'd3;
        step();
        chk("t4_pipe_src3", 64'(o2.a_source), 64'd3);
        chk("t4_pipe_count3", 64'(a_cnt2), 64'd1);
        i2.a_valid = 1'b0;
        step();
        chk("t4_drain_count", 64'(a_cnt2), 64'd0);

        // Zero-depth channels are pure wires.
        for (int p = 0; p < 2; p++) begin
            i3.a_valid   = (p == 0);
            i3.a_opcode  = (p == 0) ? 3'd5 : 3'd1;
            i3.a_param   = (p == 0) ? 3'd2 : 3'd6;
            i3.a_size    = (p == 0) ? 4'd6 : 4'd3;
            i3.a_source  = (p == 0) ? 7'h55 : 7'h2A;
            i3.a_address = (p == 0) ? 29'h1ABCDEF0 : 29'h00000123;
            i3.a_mask    = (p == 0) ? 8'hA5 : 8'h0F;
            i3.a_data    = (p == 0) ? 64'h0123456789ABCDEF : 64'hFEDCBA9876543210;
            i3.a_corrupt = (p == 0);
            o3.a_ready   = (p != 0);
            o3.d_valid   = (p != 0);
            o3.d_data    = (p == 0) ? 64'h55AA : 64'hC0FFEE;
            o3.d_sink    = (p == 0) ? 1'b1 : 1'b0;
            i3.d_ready   = (p == 0);
            settle();
            chk("t6_a_valid", 64'(o3.a_valid), (p == 0) ? 64'd1 : 64'd0);
            chk("t6_a_ready", 64'(i3.a_ready), (p == 0) ? 64'd0 : 64'd1);
            chk("t6_a_opcode", 64'(o3.a_opcode), (p == 0) ? 64'd5 : 64'd1);
            chk("t6_a_param", 64'(o3.a_param), (p == 0) ? 64'd2 : 64'd6);
            chk("t6_a_size", 64'(o3.a_size), (p == 0) ? 64'd6 : 64'd3);
            chk("t6_a_source", 64'(o3.a_source), (p == 0) ? 64'h55 : 64'h2A);
            chk("t6_a_address", 64'(o3.a_address), (p == 0) ? 64'h1ABCDEF0 : 64'h123);
            chk("t6_a_mask", 64'(o3.a_mask), (p == 0) ? 64'hA5 : 64'h0F);
            chk("t6_a_data", o3.a_data, (p == 0) ? 64'h0123456789ABCDEF : 64'hFEDCBA9876543210);
            chk("t6_a_corrupt", 64'(o3.a_corrupt), (p == 0) ? 64'd1 : 64'd0);
            chk("t6_d_valid", 64'(i3.d_valid), (p == 0) ? 64'd0 : 64'd1);
            chk("t6_d_ready", 64'(o3.d_ready), (p == 0) ? 64'd1 : 64'd0);
            chk("t6_d_data", i3.d_data, (p == 0) ? 64'h55AA : 64'hC0FFEE);
            chk("t6_d_sink", 64'(i3.d_sink), (p == 0) ? 64'd1 : 64'd0);
            chk("t6_a_count", 64'(a_cnt3), 64'd0);
            step();
        end

        // Fill D with two beats, then reset drops them.
        i0.d_ready = 1'b0;
        o0.d_valid = 1'b1; o0.d_data = 64'hA1;
        step();
        o0.d_data = 64'hA2;
        step();
        o0.d_valid = 1'b0;
        settle();
        chk("t5_fill_count", 64'(d_cnt0), 64'd2);
        chk("t5_fill_ready", 64'(o0.d_ready), 64'd0);
        chk("t5_fill_head", 64'(i0.d_data), 64'hA1);
        chk("t5_fill_idle", 64'(idle0), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        chk("t5_rst_count", 64'(d_cnt0), 64'd0);
        chk("t5_rst_valid", 64'(i0.d_valid), 64'd0);
        chk("t5_rst_ready", 64'(o0.d_ready), 64'd1);
        chk("t5_rst_idle", 64'(idle0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
